ble_cmd_wrapper: RTL
====================

# ble_cmd_wrapper

DUT-side endpoint of the Bluetooth/UART command link. It receives 16-bit commands from the remote controller as two serial bytes, high byte first, and presents them to the command processor with a ready/clear handshake. It also serializes the one-byte response, for example COMM_COMPLETE, back to the remote. It sits between the RX/TX pins of the KnightsTour top level and the command-processing state machine.

## Interface
- CLKS_PER_BIT, default 2604: clocks per UART bit (19200 baud at 50 MHz). Minimum 8.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- RX  in  1  serial input from the remote. Asynchronous; idles high.
- TX  out  1  serial output to the remote. Idles high.
- cmd  out  16  last complete command, {high byte, low byte}.
- cmd_rdy  out  1  high when cmd holds an unconsumed command.
- clr_cmd_rdy  in  1  consumer acknowledge; clears cmd_rdy.
- resp  in  8  response byte, sampled on trmt.
- trmt  in  1  one-cycle pulse that starts a response transmission.
- tx_done  out  1  high after a response finishes; held until the next accepted trmt.

## Operation
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- RX is double-flopped. The synchronizer flops reset to 1.
- Receiver:
  - A falling edge on the synchronized RX starts a frame.
  - Bit n is sampled at (n+0.5)*CLKS_PER_BIT clocks after the edge, using a single down-counter. The first load is CLKS_PER_BIT/2 (integer division); later loads are CLKS_PER_BIT.
  - Sample 0 is the start bit. If it reads 1, the edge was a glitch: return to idle, no byte produced.
  - Sample 9 is the stop bit. If it reads 0, this is a framing error: the byte is discarded.
- Wrapper FSM states:
  - WAIT_HI: on a good byte, store it as the high byte and go to WAIT_LO.
  - WAIT_LO: on a good byte, load cmd = {hi, byte}, set cmd_rdy, return to WAIT_HI.
  - On a framing error in either state, return to WAIT_HI. The partial command is dropped.
- cmd_rdy clear conditions:
  - clr_cmd_rdy high.
  - The start edge of the next high byte.
  - If the set and a clear condition occur in the same cycle, set wins.
- cmd is only updated on completion of a full command. It is stable while cmd_rdy is high.
- Transmitter:
  - TX_IDLE: on trmt, latch resp into a 10-bit shift register {1, resp, 0}, clear tx_done, go to TX_SHIFT.
  - TX_SHIFT: shift once every CLKS_PER_BIT clocks. After 10 bit-times, set tx_done and go to TX_IDLE.
  - trmt while in TX_SHIFT is ignored; the in-progress byte is unaffected.
- RX and TX are fully independent and may be active simultaneously.
- Reset values: TX=1, cmd=16'h0000, cmd_rdy=0, tx_done=0. Both FSMs go idle.
- Reset asserted mid-frame aborts the frame with no output pulse. TX returns to 1 on the next clock edge.

## Timing
- The first sample point lands CLKS_PER_BIT/2 + 2 clocks after the RX pin falls; the extra 2 clocks are synchronizer latency.
- cmd and cmd_rdy update on the clock edge after the low byte's stop-bit sample. That is 9.5*CLKS_PER_BIT + 3 clocks after the low byte's start edge at the pin, ±1 clock.
- TX drives the start bit on the clock edge after trmt.
- tx_done rises exactly 10*CLKS_PER_BIT + 1 clocks after the trmt cycle.
- There is no minimum inter-byte gap. The receiver accepts a new start edge in the cycle after the stop-bit sample.
- There is no inter-byte timeout. A lone high byte waits indefinitely for the low byte.

## Structure
- Shared package (the same package that holds the bench command constants):
  - enum rx_state_t {WAIT_HI, WAIT_LO}
  - enum tx_state_t {TX_IDLE, TX_SHIFT}
  - localparam COMM_COMPLETE = 8'hA5
  - default CLKS_PER_BIT
- One sub-module, uart_rx_core: synchronizer, bit timer and shift register.
  - Outputs: rx_byte[7:0], rx_good (one-cycle pulse), rx_ferr (one-cycle pulse), rx_start (one-cycle pulse on an accepted start edge).
  - The wrapper FSM and the transmitter stay in ble_cmd_wrapper.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- Remote sends bytes 8'h20 then 8'h00 → cmd=16'h2000 and cmd_rdy=1 within 9.5*16+4 clocks of the second start edge; clr_cmd_rdy pulse → cmd_rdy=0 next cycle, cmd unchanged.
- trmt with resp=8'hA5 → TX produces bit sequence 0,1,0,1,0,0,1,0,1,1 at 16 clocks each; tx_done rises at clock 161 after trmt; a second trmt at clock 50 is ignored.
- High byte 8'h12, then a frame whose stop bit is forced to 0, then bytes 8'h34 and 8'h56 → cmd_rdy stays 0 through the error; final cmd=16'h3456.
- A 3-clock low glitch on RX while idle → no byte accepted, FSM stays in WAIT_HI, next full command decodes correctly.
- Command 16'hBEEF is left unacknowledged, then a new start edge arrives → cmd_rdy drops at the edge; cmd holds 16'hBEEF until the new command 16'h0001 completes.
- rst asserted midway through a received low byte and a transmitted byte → next cycle TX=1, cmd_rdy=0, cmd=0; a subsequent command 16'h4321 decodes normally.

Source files
------------

// File: rtl/ble_cmd_wrapper_pkg.sv
// rtl/ble_cmd_wrapper_pkg.sv - shared types and constants for the BLE command link
package ble_cmd_wrapper_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 2604;
    localparam logic [7:0] COMM_COMPLETE = 8'hA5;

    typedef enum logic {WAIT_HI, WAIT_LO} rx_state_t;
    typedef enum logic {TX_IDLE, TX_SHIFT} tx_state_t;
    typedef enum logic {RXC_IDLE, RXC_BUSY} rx_core_state_t;

endpackage

// File: rtl/ble_cmd_wrapper_if.sv
// rtl/ble_cmd_wrapper_if.sv - command/response handshake bundle between link and command processor
interface ble_cmd_wrapper_if;

    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp;
    logic        trmt;
    logic        tx_done;

    modport master (input cmd, cmd_rdy, tx_done, output clr_cmd_rdy, resp, trmt);
    modport slave  (output cmd, cmd_rdy, tx_done, input clr_cmd_rdy, resp, trmt);

endinterface

// File: rtl/ble_cmd_wrapper_uart_rx_core.sv
// rtl/ble_cmd_wrapper_uart_rx_core.sv - UART receiver: synchronizer, bit timer, shift register
module uart_rx_core
    import ble_cmd_wrapper_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_good,
    output logic       rx_ferr,
    output logic       rx_start
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);

    logic           rx_meta_q, rx_sync_q, rx_prev_q;
    rx_core_state_t state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     bit_q, bit_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           good_q, good_d;
    logic           ferr_q, ferr_d;

    // Double-flop the asynchronous pin and keep one more stage for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Frame FSM: half-bit first load centres every later sample in its bit
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        good_d   = 1'b0;
        ferr_d   = 1'b0;
        rx_start = 1'b0;
        case (state_q)
            RXC_IDLE: begin
                if (!rx_sync_q && rx_prev_q) begin
                    rx_start = 1'b1;
                    cnt_d    = HALF;
                    bit_d    = 4'd0;
                    state_d  = RXC_BUSY;
                end
            end
            RXC_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    cnt_d = FULL;
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd0) begin
                        // a start bit that reads high was only a glitch
                        if (rx_sync_q) state_d = RXC_IDLE;
                    end else if (bit_q == 4'd9) begin
                        state_d = RXC_IDLE;
                        good_d  = rx_sync_q;
                        ferr_d  = !rx_sync_q;
                    end else begin
                        shreg_d = {rx_sync_q, shreg_q[7:1]};
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = RXC_IDLE;
        endcase
    end

    // Frame state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RXC_IDLE;
            cnt_q   <= '0;
            bit_q   <= 4'd0;
            shreg_q <= 8'h00;
            good_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            good_q  <= good_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_byte = shreg_q;
    assign rx_good = good_q;
    assign rx_ferr = ferr_q;

endmodule

// File: rtl/ble_cmd_wrapper.sv
// rtl/ble_cmd_wrapper.sv - two-byte command receiver and one-byte response transmitter
module ble_cmd_wrapper
    import ble_cmd_wrapper_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                RX,
    output logic                TX,
    ble_cmd_wrapper_if.slave    bus
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] TX_RELOAD = CW'(CLKS_PER_BIT - 1);

    logic [7:0] rx_byte;
    logic       rx_good, rx_ferr, rx_start;

    uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx       (RX),
        .rx_byte  (rx_byte),
        .rx_good  (rx_good),
        .rx_ferr  (rx_ferr),
        .rx_start (rx_start)
    );

    rx_state_t     state_q, state_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   cmd_q, cmd_d;
    logic          cmd_rdy_q, cmd_rdy_d;
    tx_state_t     tx_state_q, tx_state_d;
    logic [9:0]    tx_shreg_q, tx_shreg_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_bit_q, tx_bit_d;
    logic          tx_done_q, tx_done_d;

    // Byte pairing: a framing error drops any partial command; setting cmd_rdy beats clearing it
    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q;
        if (clr_cond()) cmd_rdy_d = 1'b0;
        if (rx_ferr) begin
            state_d = WAIT_HI;
        end else if (rx_good) begin
            if (state_q == WAIT_HI) begin
                hi_d    = rx_byte;
                state_d = WAIT_LO;
            end else begin
                cmd_d     = {hi_q, rx_byte};
                cmd_rdy_d = 1'b1;
                state_d   = WAIT_HI;
            end
        end
    end

    function automatic logic clr_cond();
        return bus.clr_cmd_rdy || (rx_start && (state_q == WAIT_HI));
    endfunction

    // Response serializer: idle shifter holds all ones so TX rests high
    always_comb begin
        tx_state_d = tx_state_q;
        tx_shreg_d = tx_shreg_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_done_d  = tx_done_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (bus.trmt) begin
                    tx_shreg_d = {1'b1, bus.resp, 1'b0};
                    tx_cnt_d   = TX_RELOAD;
                    tx_bit_d   = 4'd0;
                    tx_done_d  = 1'b0;
                    tx_state_d = TX_SHIFT;
                end
            end
            TX_SHIFT: begin
                if (tx_cnt_q == '0) begin
                    tx_shreg_d = {1'b1, tx_shreg_q[9:1]};
                    tx_cnt_d   = TX_RELOAD;
                    tx_bit_d   = tx_bit_q + 4'd1;
                    if (tx_bit_q == 4'd9) begin
                        tx_done_d  = 1'b1;
                        tx_state_d = TX_IDLE;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - CW'(1);
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    // Command and response state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_HI;
            hi_q       <= 8'h00;
            cmd_q      <= 16'h0000;
            cmd_rdy_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_shreg_q <= '1;
            tx_cnt_q   <= '0;
            tx_bit_q   <= 4'd0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hi_q       <= hi_d;
            cmd_q      <= cmd_d;
            cmd_rdy_q  <= cmd_rdy_d;
            tx_state_q <= tx_state_d;
            tx_shreg_q <= tx_shreg_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_done_q  <= tx_done_d;
        end
    end

    assign TX          = tx_shreg_q[0];
    assign bus.cmd     = cmd_q;
    assign bus.cmd_rdy = cmd_rdy_q;
    assign bus.tx_done = tx_done_q;

endmodule
